// File: rtl/cr_clic_kid_bank.sv
// rtl/cr_clic_kid_bank.sv - bank of CLIC interrupt sources with per-channel trigger modes
// and a registered max-priority pre-arbiter feeding the CLIC core.
module cr_clic_kid_bank #(
  parameter int NUM_INT     = 16,
  parameter int IDW         = 4,
  parameter int CLICINTBITS = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   sample_cpuclk,
  input  logic                   cpurst_b,
  input  logic [NUM_INT-1:0]     pad_clic_int_vld,
  input  logic                   reg_wr_vld,
  input  logic [IDW-1:0]         reg_wr_idx,
  input  logic [1:0]             reg_wr_sel,
  input  logic [7:0]             reg_wr_data,
  input  logic [IDW-1:0]         reg_rd_idx,
  output logic [31:0]            reg_rd_data,
  input  logic                   arb_kid_ack,
  input  logic [IDW-1:0]         arb_kid_ack_id,
  output logic                   kid_arb_int_req,
  output logic [IDW-1:0]         kid_arb_int_id,
  output logic [CLICINTBITS-1:0] kid_arb_int_prio,
  output logic [NUM_INT-1:0]     kid_xx_ip,
  output logic [NUM_INT-1:0]     kid_xx_ie
);

  localparam logic [1:0] SEL_IP      = 2'd0;
  localparam logic [1:0] SEL_IE      = 2'd1;
  localparam logic [1:0] SEL_ATTR    = 2'd2;
  localparam logic [1:0] SEL_CTL     = 2'd3;
  localparam logic [1:0] TRIG_LVL_HI = 2'b00;
  localparam logic [1:0] TRIG_RISE   = 2'b01;
  localparam logic [1:0] TRIG_LVL_LO = 2'b10;
  localparam logic [1:0] TRIG_FALL   = 2'b11;
  localparam logic [7:0] CTL_LOW_ONES = 8'hFF >> CLICINTBITS;

  logic [NUM_INT-1:0]     s;
  logic [NUM_INT-1:0]     s_ff_q;
  logic [NUM_INT-1:0]     rise;
  logic [NUM_INT-1:0]     fall;
  logic [NUM_INT-1:0]     wr_hit;
  logic [NUM_INT-1:0]     ack_hit;
  logic [NUM_INT-1:0]     cand;
  logic [NUM_INT-1:0]     ip_q, ip_d;
  logic [NUM_INT-1:0]     ie_q, ie_d;
  logic [1:0]             attr_q [NUM_INT];
  logic [1:0]             attr_d [NUM_INT];
  logic [CLICINTBITS-1:0] prio_q [NUM_INT];
  logic [CLICINTBITS-1:0] prio_d [NUM_INT];
  logic                   req_q, req_d;
  logic [IDW-1:0]         id_q, id_d;
  logic [CLICINTBITS-1:0] win_prio_q, win_prio_d;
  logic                   unused_wr_data;

  assign unused_wr_data = ^reg_wr_data;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = pad_clic_int_vld;
    end else begin : g_sync
      logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge sample_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= pad_clic_int_vld;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = s & ~s_ff_q;
  assign fall = ~s & s_ff_q;
  assign cand = ip_q & ie_q;

  // Out-of-range indices match no channel, so such writes and acks fall away here.
  always_comb begin
    wr_hit  = '0;
    ack_hit = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      wr_hit[i]  = reg_wr_vld && (reg_wr_idx == IDW'(i));
      ack_hit[i] = arb_kid_ack && (arb_kid_ack_id == IDW'(i));
    end
  end

  always_comb begin
    ip_d   = ip_q;
    ie_d   = ie_q;
    attr_d = attr_q;
    prio_d = prio_q;
    for (int i = 0; i < NUM_INT; i++) begin
      if (wr_hit[i] && reg_wr_sel == SEL_ATTR) begin
        ip_d[i] = 1'b0;
      end else begin
        case (attr_q[i])
          TRIG_LVL_HI: ip_d[i] = s[i];
          TRIG_LVL_LO: ip_d[i] = ~s[i];
          default: begin
            // Edge beats software write and ack so a coincident edge is never lost.
            if ((attr_q[i] == TRIG_RISE && rise[i]) || (attr_q[i] == TRIG_FALL && fall[i]))
              ip_d[i] = 1'b1;
            else if (wr_hit[i] && reg_wr_sel == SEL_IP)
              ip_d[i] = reg_wr_data[0];
            else if (ack_hit[i])
              ip_d[i] = 1'b0;
          end
        endcase
      end
      if (wr_hit[i]) begin
        case (reg_wr_sel)
          SEL_IE:   ie_d[i]   = reg_wr_data[0];
          SEL_ATTR: attr_d[i] = reg_wr_data[1:0];
          SEL_CTL:  prio_d[i] = reg_wr_data[7 -: CLICINTBITS];
          default:  ;
        endcase
      end
    end
  end

  // Strictly-greater compare keeps the lowest index on priority ties.
  always_comb begin
    req_d      = 1'b0;
    id_d       = '0;
    win_prio_d = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      if (cand[i] && (!req_d || prio_q[i] > win_prio_d)) begin
        req_d      = 1'b1;
        id_d       = IDW'(i);
        win_prio_d = prio_q[i];
      end
    end
  end

  always_comb begin
    reg_rd_data = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      if (reg_rd_idx == IDW'(i))
        reg_rd_data = {(8'(prio_q[i]) << (8 - CLICINTBITS)) | CTL_LOW_ONES,
                       6'b0, attr_q[i], 7'b0, ie_q[i], 7'b0, ip_q[i]};
    end
  end

  always_ff @(posedge sample_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      s_ff_q     <= '0;
      ip_q       <= '0;
      ie_q       <= '0;
      req_q      <= 1'b0;
      id_q       <= '0;
      win_prio_q <= '0;
      for (int i = 0; i < NUM_INT; i++) begin
        attr_q[i] <= '0;
        prio_q[i] <= '0;
      end
    end else begin
      s_ff_q     <= s;
      ip_q       <= ip_d;
      ie_q       <= ie_d;
      req_q      <= req_d;
      id_q       <= id_d;
      win_prio_q <= win_prio_d;
      attr_q     <= attr_d;
      prio_q     <= prio_d;
    end
  end

  assign kid_arb_int_req  = req_q;
  assign kid_arb_int_id   = id_q;
  assign kid_arb_int_prio = win_prio_q;
  assign kid_xx_ip        = ip_q;
  assign kid_xx_ie        = ie_q;

endmodule

// File: tb/tb_cr_clic_kid_bank.sv
// tb/tb_cr_clic_kid_bank.sv - self-checking bench for cr_clic_kid_bank
// Reference model runs alongside; 12 channels so out-of-range indices are reachable.
module tb_cr_clic_kid_bank;
  localparam int N = 12, IDW = 4, CB = 3, SYNC = 2;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic [N-1:0]    pads = '0;
  logic            wr_vld = 1'b0;
  logic [IDW-1:0]  wr_idx = '0;
  logic [1:0]      wr_sel = '0;
  logic [7:0]      wr_data = '0;
  logic [IDW-1:0]  rd_idx = '0;
  logic [31:0]     rd_data;
  logic            ack = 1'b0;
  logic [IDW-1:0]  ack_id = '0;
  logic            req;
  logic [IDW-1:0]  id;
  logic [CB-1:0]   prio;
  logic [N-1:0]    ip, ie;

  int n_chk = 0, n_fail = 0;

  cr_clic_kid_bank #(.NUM_INT(N), .IDW(IDW), .CLICINTBITS(CB), .SYNC_STAGES(SYNC)) dut (
    .sample_cpuclk(clk), .cpurst_b(rst_b), .pad_clic_int_vld(pads),
    .reg_wr_vld(wr_vld), .reg_wr_idx(wr_idx), .reg_wr_sel(wr_sel), .reg_wr_data(wr_data),
    .reg_rd_idx(rd_idx), .reg_rd_data(rd_data), .arb_kid_ack(ack), .arb_kid_ack_id(ack_id),
    .kid_arb_int_req(req), .kid_arb_int_id(id), .kid_arb_int_prio(prio),
    .kid_xx_ip(ip), .kid_xx_ie(ie));

  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0]   m_ip, m_ie, m_sff;
  logic [1:0]     m_attr [N];
  logic [CB-1:0]  m_pr [N];
  logic [N-1:0]   m_hist [SYNC];
  logic           m_req;
  logic [IDW-1:0] m_id;
  logic [CB-1:0]  m_prio;

  task automatic model_reset();
    m_ip = '0; m_ie = '0; m_sff = '0;
    m_req = 1'b0; m_id = '0; m_prio = '0;
    for (int i = 0; i < N; i++) begin m_attr[i] = 2'b00; m_pr[i] = '0; end
    for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] sv, nip;
    logic         wr, edge_seen;
    sv = m_hist[0];
    m_req = 1'b0; m_id = '0; m_prio = '0;
    for (int p = (1 << CB) - 1; p >= 0; p--)
      for (int i = 0; i < N; i++)
        if (!m_req && m_ip[i] && m_ie[i] && int'(m_pr[i]) == p) begin
          m_req = 1'b1; m_id = IDW'(i); m_prio = CB'(p);
        end
    nip = m_ip;
    for (int i = 0; i < N; i++) begin
      wr = wr_vld && int'(wr_idx) == i;
      if (wr && wr_sel == 2'd2) nip[i] = 1'b0;
      else if (m_attr[i] == 2'b00) nip[i] = sv[i];
      else if (m_attr[i] == 2'b10) nip[i] = !sv[i];
      else begin
        edge_seen = (m_attr[i] == 2'b01) ? (sv[i] && !m_sff[i]) : (!sv[i] && m_sff[i]);
        if (edge_seen) nip[i] = 1'b1;
        else if (wr && wr_sel == 2'd0) nip[i] = wr_data[0];
        else if (ack && int'(ack_id) == i) nip[i] = 1'b0;
      end
      if (wr && wr_sel == 2'd1) m_ie[i] = wr_data[0];
      if (wr && wr_sel == 2'd2) m_attr[i] = wr_data[1:0];
      if (wr && wr_sel == 2'd3) m_pr[i] = wr_data[7:8-CB];
    end
    m_ip = nip;
    m_sff = sv;
    for (int k = 0; k < SYNC - 1; k++) m_hist[k] = m_hist[k+1];
    m_hist[SYNC-1] = pads;
  endtask

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) model_reset();
    else model_step();
  end

  function automatic logic [31:0] m_rd(input logic [IDW-1:0] idx);
    logic [7:0] ctl;
    if (int'(idx) >= N) return 32'h0;
    ctl = {m_pr[idx], {(8-CB){1'b1}}};
    return {ctl, 6'b0, m_attr[idx], 7'b0, m_ie[idx], 7'b0, m_ip[idx]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("ip_vs_model", 32'(ip), 32'(m_ip));
    chk("ie_vs_model", 32'(ie), 32'(m_ie));
    chk("req_vs_model", 32'(req), 32'(m_req));
    chk("id_vs_model", 32'(id), 32'(m_id));
    chk("prio_vs_model", 32'(prio), 32'(m_prio));
    chk("rd_vs_model", rd_data, m_rd(rd_idx));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [IDW-1:0] idx, input logic [7:0] data);
    wr_vld = 1'b1; wr_sel = sel; wr_idx = idx; wr_data = data;
    cyc();
    wr_vld = 1'b0;
  endtask

  typedef struct {
    logic [1:0]     sel;
    logic [IDW-1:0] idx;
    logic [7:0]     data;
    logic [IDW-1:0] rd;
    logic [31:0]    exp;
  } vec_t;
  vec_t vecs [10];

  initial begin
    vecs[0] = '{2'd3, 4'd0,  8'hFF, 4'd0,  32'hFF00_0000};
    vecs[1] = '{2'd3, 4'd0,  8'h00, 4'd0,  32'h1F00_0000};
    vecs[2] = '{2'd3, 4'd0,  8'hA5, 4'd0,  32'hBF00_0000};
    vecs[3] = '{2'd2, 4'd0,  8'hFD, 4'd0,  32'hBF01_0000};
    vecs[4] = '{2'd1, 4'd0,  8'hFF, 4'd0,  32'hBF01_0100};
    vecs[5] = '{2'd0, 4'd0,  8'h01, 4'd0,  32'hBF01_0101};
    vecs[6] = '{2'd0, 4'd0,  8'h00, 4'd0,  32'hBF01_0100};
    vecs[7] = '{2'd3, 4'd12, 8'hFF, 4'd12, 32'h0000_0000};
    vecs[8] = '{2'd1, 4'd15, 8'hFF, 4'd0,  32'hBF01_0100};
    vecs[9] = '{2'd2, 4'd0,  8'h00, 4'd0,  32'hBF00_0100};

    // 1: reset state, then all pads high with ie=0
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_id", 32'(id), 32'h0);
    chk("rst_prio", 32'(prio), 32'h0);
    chk("rst_ip", 32'(ip), 32'h0);
    chk("rst_rd", rd_data, 32'h1F00_0000);
    pads = '1;
    @(negedge clk);
    rst_b = 1'b1;
    cyc(); cyc();
    chk("lvl_ip_early", 32'(ip), 32'h0);
    cyc();
    chk("lvl_ip_all", 32'(ip), 32'hFFF);
    chk("lvl_req0", 32'(req), 32'h0);
    cyc();
    chk("lvl_req0b", 32'(req), 32'h0);
    pads = '0;
    repeat (4) cyc();

    // 2: rising edge pulse on ch3, arbitration, ack
    wr(2'd2, 4'd3, 8'h01); wr(2'd1, 4'd3, 8'h01); wr(2'd3, 4'd3, 8'hE0);
    pads[3] = 1'b1; cyc(); pads[3] = 1'b0; cyc();
    chk("ch3_ip_early", 32'(ip[3]), 32'h0);
    cyc();
    chk("ch3_ip", 32'(ip[3]), 32'h1);
    cyc();
    chk("ch3_req", 32'(req), 32'h1);
    chk("ch3_id", 32'(id), 32'h3);
    chk("ch3_prio", 32'(prio), 32'h7);
    ack = 1'b1; ack_id = 4'd3; cyc(); ack = 1'b0;
    chk("ch3_ack_ip", 32'(ip[3]), 32'h0);
    cyc();
    chk("ch3_req_drop", 32'(req), 32'h0);

    // 3: tie goes to lower index, then priority raise
    wr(2'd1, 4'd3, 8'h00);
    wr(2'd2, 4'd2, 8'h01); wr(2'd2, 4'd5, 8'h01);
    wr(2'd1, 4'd2, 8'h01); wr(2'd1, 4'd5, 8'h01);
    wr(2'd3, 4'd2, 8'h60); wr(2'd3, 4'd5, 8'h60);
    pads[2] = 1'b1; pads[5] = 1'b1; cyc(); pads = '0;
    repeat (3) cyc();
    chk("tie_req", 32'(req), 32'h1);
    chk("tie_id", 32'(id), 32'h2);
    chk("tie_prio", 32'(prio), 32'h3);
    wr(2'd3, 4'd5, 8'h80);
    cyc();
    chk("raise_id", 32'(id), 32'h5);
    chk("raise_prio", 32'(prio), 32'h4);
    wr(2'd1, 4'd2, 8'h00); wr(2'd1, 4'd5, 8'h00);

    // 4: falling edge coincident with ack, then software clear
    wr(2'd2, 4'd7, 8'h03);
    pads[7] = 1'b1; repeat (4) cyc();
    chk("ch7_no_rise", 32'(ip[7]), 32'h0);
    pads[7] = 1'b0; cyc(); cyc();
    ack = 1'b1; ack_id = 4'd7; cyc(); ack = 1'b0;
    chk("ch7_edge_ack", 32'(ip[7]), 32'h1);
    wr(2'd0, 4'd7, 8'h00);
    chk("ch7_sw_clr", 32'(ip[7]), 32'h0);

    // 5: level-low ch1 ignores sw/ack, attr write clears
    wr(2'd2, 4'd1, 8'h02);
    chk("ch1_attr_clr", 32'(ip[1]), 32'h0);
    cyc();
    chk("ch1_lvl_lo", 32'(ip[1]), 32'h1);
    wr(2'd0, 4'd1, 8'h00);
    chk("ch1_sw_ign", 32'(ip[1]), 32'h1);
    ack = 1'b1; ack_id = 4'd1; cyc(); ack = 1'b0;
    chk("ch1_ack_ign", 32'(ip[1]), 32'h1);
    wr(2'd2, 4'd1, 8'h01);
    chk("ch1_to_rise", 32'(ip[1]), 32'h0);
    repeat (3) cyc();
    chk("ch1_stay0", 32'(ip[1]), 32'h0);

    // 6: register vectors on ch0 and out-of-range index
    for (int j = 0; j < 10; j++) begin
      rd_idx = vecs[j].rd;
      wr(vecs[j].sel, vecs[j].idx, vecs[j].data);
      chk($sformatf("vec%0d", j), rd_data, vecs[j].exp);
    end

    // randomized run against the model
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) pads[b] = ~pads[b];
      wr_vld  = ($urandom_range(3) == 0);
      wr_idx  = IDW'($urandom_range(15));
      wr_sel  = 2'($urandom_range(3));
      wr_data = 8'($urandom);
      ack     = ($urandom_range(2) == 0);
      ack_id  = ($urandom_range(1) == 0) ? m_id : IDW'($urandom_range(15));
      rd_idx  = IDW'($urandom_range(15));
      cyc();
    end
    wr_vld = 1'b0; ack = 1'b0; pads = '0;
    repeat (4) cyc();

    // reset asserted while ch3 is pending
    wr(2'd2, 4'd3, 8'h01); wr(2'd1, 4'd3, 8'h01);
    rd_idx = 4'd3;
    pads[3] = 1'b1; cyc(); pads[3] = 1'b0;
    repeat (3) cyc();
    chk("pre_rst_ip3", 32'(ip[3]), 32'h1);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_ip", 32'(ip), 32'h0);
    chk("mid_rst_ie", 32'(ie), 32'h0);
    chk("mid_rst_req", 32'(req), 32'h0);
    chk("mid_rst_id", 32'(id), 32'h0);
    chk("mid_rst_prio", 32'(prio), 32'h0);
    chk("mid_rst_rd", rd_data, 32'h1F00_0000);
    @(negedge clk);
    rst_b = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
